// File: rtl/aes_iter_core.sv
// Iterative AES-128/192/256 engine: one round per clock, round keys expanded
// once per key load (one word per cycle) and held for many blocks.
module aes_iter_core #(
  parameter int unsigned NK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_load,
  input  logic [32*NK-1:0]  key_in,
  output logic              key_valid,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_data,
  input  logic              in_decrypt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data,
  output logic              busy
);

  localparam int unsigned NR     = NK + 6;
  localparam int unsigned NW     = 4 * (NR + 1);
  localparam int unsigned WIDX_W = 6;
  localparam int unsigned RND_W  = 4;
  localparam int unsigned KMOD_W = 3;

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("aes_iter_core: NK must be 4, 6 or 8");
  end

  // Byte 0 of the block sits at index 0 (the most significant byte).
  typedef logic [0:15][7:0] blk_t;
  typedef enum logic [1:0] {S_IDLE, S_KEYX, S_RUN, S_DONE} state_e;

  // ---------------------------------------------------------------- GF(2^8)
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = '0;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] res, p;
    res = 8'h01;
    p   = a;
    for (int i = 0; i < 7; i++) begin
      p   = gf_mul(p, p);
      res = gf_mul(res, p);
    end
    return res;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] b;
    b = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // ------------------------------------------------------- round primitives
  function automatic blk_t sub_bytes(input blk_t s);
    blk_t o;
    for (int k = 0; k < 16; k++) o[4'(k)] = sbox(s[4'(k)]);
    return o;
  endfunction

  function automatic blk_t inv_sub_bytes(input blk_t s);
    blk_t o;
    for (int k = 0; k < 16; k++) o[4'(k)] = inv_sbox(s[4'(k)]);
    return o;
  endfunction

  function automatic blk_t shift_rows(input blk_t s);
    blk_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[4'(4*c + r)] = s[4'(4*((c + r) % 4) + r)];
    return o;
  endfunction

  function automatic blk_t inv_shift_rows(input blk_t s);
    blk_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[4'(4*c + r)] = s[4'(4*((c - r + 4) % 4) + r)];
    return o;
  endfunction

  // Circulant column mix; (2,3,1,1) forward, (e,b,d,9) inverse.
  function automatic blk_t mix(input blk_t s, input logic [7:0] m0, input logic [7:0] m1,
                               input logic [7:0] m2, input logic [7:0] m3);
    blk_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[4'(4*c + r)] = gf_mul(s[4'(4*c + r)], m0)
                       ^ gf_mul(s[4'(4*c + (r + 1) % 4)], m1)
                       ^ gf_mul(s[4'(4*c + (r + 2) % 4)], m2)
                       ^ gf_mul(s[4'(4*c + (r + 3) % 4)], m3);
    return o;
  endfunction

  // ---------------------------------------------------------------- state
  state_e              r_state, w_state_nxt;
  logic                r_key_valid;
  logic                r_out_valid;
  logic [127:0]        r_out_data;
  logic [127:0]        r_state_d;
  logic                r_mode;
  logic [RND_W-1:0]    r_round;
  logic [WIDX_W-1:0]   r_widx;
  logic [KMOD_W-1:0]   r_kmod;
  logic [7:0]          r_rcon;
  logic [31:0]         r_rk_w [0:NW-1];
  logic [31:0]         r_win  [0:NK-1];

  logic [31:0]         w_key_w [0:NK-1];
  logic [127:0]        w_rk    [0:NR];
  logic [31:0]         w_ktemp, w_knew;
  logic                w_key_last, w_key_start, w_accept, w_last;
  logic [127:0]        w_rk_enc, w_rk_dec, w_e_sr, w_enc, w_d_ark, w_dec, w_round_out;

  for (genvar g = 0; g < NK; g++) begin : g_key_words
    assign w_key_w[g] = key_in[32*(NK-1-g) +: 32];
  end

  for (genvar g = 0; g < NR + 1; g++) begin : g_rk_view
    assign w_rk[g] = {r_rk_w[4*g], r_rk_w[4*g+1], r_rk_w[4*g+2], r_rk_w[4*g+3]};
  end

  assign key_valid = r_key_valid;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // Next key-schedule word from the sliding window of the last NK words.
  always_comb begin
    w_ktemp = r_win[NK-1];
    if (r_kmod == '0)
      w_ktemp = sub_word({r_win[NK-1][23:0], r_win[NK-1][31:24]}) ^ {r_rcon, 24'h0};
    else if ((NK == 8) && (r_kmod == KMOD_W'(4)))
      w_ktemp = sub_word(r_win[NK-1]);
    w_knew     = r_win[0] ^ w_ktemp;
    w_key_last = (r_widx == WIDX_W'(NW - 1));
  end

  // One encrypt or decrypt round on the current state.
  always_comb begin
    w_rk_enc    = w_rk[r_round];
    w_rk_dec    = w_rk[RND_W'(NR) - r_round];
    w_e_sr      = shift_rows(sub_bytes(r_state_d));
    w_enc       = (w_last ? w_e_sr : mix(w_e_sr, 8'h02, 8'h03, 8'h01, 8'h01)) ^ w_rk_enc;
    w_d_ark     = inv_sub_bytes(inv_shift_rows(r_state_d)) ^ w_rk_dec;
    w_dec       = w_last ? w_d_ark : mix(w_d_ark, 8'h0e, 8'h0b, 8'h0d, 8'h09);
    w_round_out = r_mode ? w_dec : w_enc;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_key_start)   w_state_nxt = S_KEYX;
        else if (w_accept) w_state_nxt = S_RUN;
      end
      S_KEYX: if (w_key_last) w_state_nxt = S_IDLE;
      S_RUN:  if (w_last)     w_state_nxt = S_DONE;
      S_DONE: if (out_ready)  w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // FSM decoded outputs and strobes.
  always_comb begin
    in_ready    = (r_state == S_IDLE) && r_key_valid && !key_load;
    busy        = (r_state != S_IDLE);
    w_key_start = (r_state == S_IDLE) && key_load;
    w_accept    = in_valid && in_ready;
    w_last      = (r_round == RND_W'(NR));
  end

  // Key schedule, round datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_valid <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_state_d   <= '0;
      r_mode      <= 1'b0;
      r_round     <= '0;
      r_widx      <= '0;
      r_kmod      <= '0;
      r_rcon      <= '0;
      for (int j = 0; j < NW; j++) r_rk_w[j] <= '0;
      for (int j = 0; j < NK; j++) r_win[j]  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_key_start) begin
            r_key_valid <= 1'b0;
            for (int j = 0; j < NK; j++) begin
              r_rk_w[j] <= w_key_w[j];
              r_win[j]  <= w_key_w[j];
            end
            r_widx <= WIDX_W'(NK);
            r_kmod <= '0;
            r_rcon <= 8'h01;
          end else if (w_accept) begin
            r_mode    <= in_decrypt;
            r_state_d <= in_data ^ (in_decrypt ? w_rk[NR] : w_rk[0]);
            r_round   <= RND_W'(1);
          end
        end
        S_KEYX: begin
          r_rk_w[r_widx] <= w_knew;
          for (int j = 0; j < NK - 1; j++) r_win[j] <= r_win[j+1];
          r_win[NK-1] <= w_knew;
          r_widx      <= r_widx + WIDX_W'(1);
          r_kmod      <= (r_kmod == KMOD_W'(NK - 1)) ? '0 : r_kmod + KMOD_W'(1);
          if (r_kmod == '0) r_rcon <= xtime(r_rcon);
          if (w_key_last)   r_key_valid <= 1'b1;
        end
        S_RUN: begin
          r_state_d <= w_round_out;
          if (w_last) begin
            r_out_data  <= w_round_out;
            r_out_valid <= 1'b1;
            r_round     <= '0;
          end else begin
            r_round <= r_round + RND_W'(1);
          end
        end
        S_DONE: if (out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iter_core.sv
// Directed FIPS-197 vectors against AES-128/192/256 instances of aes_iter_core.
module tb_aes_iter_core;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         key_load [3];
  logic         key_valid[3];
  logic         in_valid [3];
  logic         in_ready [3];
  logic         in_decrypt[3];
  logic         out_valid[3];
  logic         out_ready[3];
  logic         busy     [3];
  logic [127:0] in_data  [3];
  logic [127:0] out_data [3];
  logic [127:0] key_in4;
  logic [191:0] key_in6;
  logic [255:0] key_in8;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [255:0] KEY_A   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY_B   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY_256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_A    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_A    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_iter_core #(.NK(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .key_load(key_load[0]), .key_in(key_in4), .key_valid(key_valid[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_decrypt(in_decrypt[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0]));

  aes_iter_core #(.NK(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .key_load(key_load[1]), .key_in(key_in6), .key_valid(key_valid[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_decrypt(in_decrypt[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1]));

  aes_iter_core #(.NK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .key_load(key_load[2]), .key_in(key_in8), .key_valid(key_valid[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]), .in_decrypt(in_decrypt[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2]));

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nr_of(input int d);
    return 10 + 2 * d;
  endfunction

  task automatic set_key(input logic [255:0] k);
    key_in4 = k[255:128];
    key_in6 = k[255:64];
    key_in8 = k;
  endtask

  task automatic load_key(input int d, input logic [255:0] k, input string tag);
    int n;
    int bound;
    bound = 4 * (nr_of(d) + 1) + 2;
    @(negedge clk);
    set_key(k);
    key_load[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_load[d] = 1'b0;
    check_eq({tag, "_kv_clr"}, 128'(key_valid[d]), 128'd0);
    check_eq({tag, "_busy_kx"}, 128'(busy[d]), 128'd1);
    n = 0;
    while (!key_valid[d] && n < bound + 10) begin
      @(posedge clk); n++; @(negedge clk);
    end
    check_eq({tag, "_kv_set"}, 128'(key_valid[d]), 128'd1);
    check_eq({tag, "_klat_ok"}, 128'(n <= bound), 128'd1);
  endtask

  task automatic run_block(input int d, input logic dec, input logic [127:0] din,
                           input logic [127:0] exp, input int hold, input bit inject,
                           input string tag);
    int n;
    int bad;
    @(negedge clk);
    n = 0;
    while (!in_ready[d] && n < 20) begin
      @(negedge clk); n++;
    end
    check_eq({tag, "_in_ready"}, 128'(in_ready[d]), 128'd1);
    in_valid[d]   = 1'b1;
    in_data[d]    = din;
    in_decrypt[d] = dec;
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
    in_data[d]  = '0;
    check_eq({tag, "_busy_run"}, 128'(busy[d]), 128'd1);
    n = 0;
    while (!out_valid[d] && n < nr_of(d) + 10) begin
      @(posedge clk); n++; @(negedge clk);
      if (inject && n == 3) begin
        set_key(KEY_A);
        key_load[d] = 1'b1;
      end
      if (inject && n == 4) key_load[d] = 1'b0;
    end
    check_eq({tag, "_latency"}, 128'(n), 128'(nr_of(d)));
    check_eq({tag, "_data"}, out_data[d], exp);
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (out_data[d] !== exp || in_ready[d] !== 1'b0 || busy[d] !== 1'b1 || out_valid[d] !== 1'b1)
        bad++;
    end
    if (hold > 0) check_eq({tag, "_bp_bad_cycles"}, 128'(bad), 128'd0);
    out_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[d] = 1'b0;
    check_eq({tag, "_ov_clr"}, 128'(out_valid[d]), 128'd0);
    check_eq({tag, "_data_kept"}, out_data[d], exp);
    check_eq({tag, "_ready_again"}, 128'(in_ready[d]), 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hi;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      key_load[d] = 1'b0; in_valid[d] = 1'b0; in_decrypt[d] = 1'b0;
      out_ready[d] = 1'b0; in_data[d] = '0;
    end
    set_key('0);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check_eq("rst_out_valid", 128'(out_valid[d]), 128'd0);
      check_eq("rst_key_valid", 128'(key_valid[d]), 128'd0);
      check_eq("rst_in_ready",  128'(in_ready[d]),  128'd0);
      check_eq("rst_busy",      128'(busy[d]),      128'd0);
      check_eq("rst_out_data",  out_data[d],        128'd0);
    end
    rst_n = 1'b1;

    load_key(0, KEY_A, "k128a");
    run_block(0, 1'b0, PT_A, CT_A, 0, 1'b0, "enc_appb");

    load_key(0, KEY_B, "k128b");
    run_block(0, 1'b0, PT_B, CT_128, 0, 1'b0, "enc128");
    run_block(0, 1'b1, CT_128, PT_B, 0, 1'b0, "dec128");

    load_key(1, KEY_192, "k192");
    run_block(1, 1'b0, PT_B, CT_192, 0, 1'b0, "enc192");
    run_block(1, 1'b1, CT_192, PT_B, 0, 1'b0, "dec192");

    load_key(2, KEY_256, "k256");
    run_block(2, 1'b0, PT_B, CT_256, 0, 1'b0, "enc256");
    run_block(2, 1'b1, CT_256, PT_B, 0, 1'b0, "dec256");

    run_block(0, 1'b0, PT_B, CT_128, 20, 1'b0, "bp");
    run_block(0, 1'b1, CT_128, PT_B, 0, 1'b0, "after_bp");

    // key_load beats in_valid in IDLE
    @(negedge clk);
    set_key(KEY_B);
    key_load[0] = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0]  = PT_B;
    #1;
    check_eq("prio_in_ready", 128'(in_ready[0]), 128'd0);
    @(posedge clk);
    @(negedge clk);
    key_load[0] = 1'b0;
    in_valid[0] = 1'b0;
    check_eq("prio_kv_drop", 128'(key_valid[0]), 128'd0);
    n = 0;
    while (!key_valid[0] && n < 60) begin
      @(posedge clk); n++; @(negedge clk);
    end
    check_eq("prio_kv_back", 128'(key_valid[0]), 128'd1);
    check_eq("prio_busy_idle", 128'(busy[0]), 128'd0);
    hi = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b0) hi++;
    end
    check_eq("prio_no_block", 128'(hi), 128'd0);

    // key_load during RUN is ignored; result still under KEY_B
    run_block(0, 1'b0, PT_B, CT_128, 0, 1'b1, "inject");
    check_eq("inject_kv", 128'(key_valid[0]), 128'd1);
    run_block(0, 1'b1, CT_128, PT_B, 0, 1'b0, "inject_dec");

    // Reset mid-RUN
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = PT_B; in_decrypt[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_out_valid", 128'(out_valid[0]), 128'd0);
    check_eq("mrst_key_valid", 128'(key_valid[0]), 128'd0);
    check_eq("mrst_in_ready",  128'(in_ready[0]),  128'd0);
    check_eq("mrst_busy",      128'(busy[0]),      128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid[0] = 1'b1;
    hi = 0;
    repeat (5) begin
      @(negedge clk);
      if (in_ready[0] !== 1'b0 || busy[0] !== 1'b0) hi++;
    end
    in_valid[0] = 1'b0;
    check_eq("mrst_stay_idle", 128'(hi), 128'd0);
    load_key(0, KEY_B, "k_after_rst");
    run_block(0, 1'b0, PT_B, CT_128, 0, 1'b0, "enc_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
